// File: rtl/rs_read_encoder.sv
// rs_read_encoder
// Streaming systematic Reed-Solomon encoder over GF(16) (x^4+x+1), four parity
// symbols. Message symbols pass straight through; the remainder of
// data(x)*x^4 mod g(x) follows as four parity symbols, highest degree first.
module rs_read_encoder #(
    parameter int K = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_sym,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_sym,
    output logic       out_parity,
    output logic       out_last
);

    typedef enum logic [0:0] {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    // Generator g(x) = x^4 + D x^3 + C x^2 + 8 x + 7
    localparam logic [3:0] G3     = 4'hD;
    localparam logic [3:0] G2     = 4'hC;
    localparam logic [3:0] G1     = 4'h8;
    localparam logic [3:0] G0     = 4'h7;
    localparam logic [3:0] K_LAST = 4'(K - 1);

    // GF(16) product, reducing by x^4 = x + 1; constant operands fold to XOR trees
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end else begin
                acc = acc;
            end
            if (sh[3]) begin
                sh = {sh[2:0], 1'b0} ^ 4'h3;
            end else begin
                sh = {sh[2:0], 1'b0};
            end
        end
        return acc;
    endfunction

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic [3:0] p3_r, p2_r, p1_r, p0_r;
    logic [3:0] p3_s, p2_s, p1_s, p0_s;
    logic       out_valid_r, out_valid_s;
    logic [3:0] out_sym_r, out_sym_s;
    logic       out_parity_r, out_parity_s;
    logic       out_last_r, out_last_s;
    logic       free_s;
    logic       in_ready_s;
    logic       accept_s;
    logic [3:0] fb_s;

    // Next-state, LFSR update and output-register load decisions
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        p3_s         = p3_r;
        p2_s         = p2_r;
        p1_s         = p1_r;
        p0_s         = p0_r;
        out_valid_s  = out_valid_r;
        out_sym_s    = out_sym_r;
        out_parity_s = out_parity_r;
        out_last_s   = out_last_r;

        free_s     = !out_valid_r || out_ready;
        in_ready_s = (state_r == ST_DATA) && free_s;
        accept_s   = in_valid && in_ready_s;
        fb_s       = in_sym ^ p3_r;

        case (state_r)
            ST_DATA: begin
                if (accept_s) begin
                    p3_s         = p2_r ^ gf_mul(fb_s, G3);
                    p2_s         = p1_r ^ gf_mul(fb_s, G2);
                    p1_s         = p0_r ^ gf_mul(fb_s, G1);
                    p0_s         = gf_mul(fb_s, G0);
                    out_sym_s    = in_sym;
                    out_valid_s  = 1'b1;
                    out_parity_s = 1'b0;
                    out_last_s   = 1'b0;
                    if (cnt_r == K_LAST) begin
                        cnt_s   = 4'd0;
                        state_s = ST_PARITY;
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end else if (out_ready) begin
                    out_valid_s = 1'b0;
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            ST_PARITY: begin
                if (free_s) begin
                    out_sym_s    = p3_r;
                    out_valid_s  = 1'b1;
                    out_parity_s = 1'b1;
                    p3_s         = p2_r;
                    p2_s         = p1_r;
                    p1_s         = p0_r;
                    p0_s         = 4'h0;
                    if (cnt_r == 4'd3) begin
                        out_last_s = 1'b1;
                        cnt_s      = 4'd0;
                        state_s    = ST_DATA;
                    end else begin
                        out_last_s = 1'b0;
                        cnt_s      = cnt_r + 4'd1;
                    end
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            default: begin
                state_s = ST_DATA;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, LFSR and output registers; reset discards any partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_DATA;
            cnt_r        <= 4'd0;
            p3_r         <= 4'h0;
            p2_r         <= 4'h0;
            p1_r         <= 4'h0;
            p0_r         <= 4'h0;
            out_valid_r  <= 1'b0;
            out_sym_r    <= 4'h0;
            out_parity_r <= 1'b0;
            out_last_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            p3_r         <= p3_s;
            p2_r         <= p2_s;
            p1_r         <= p1_s;
            p0_r         <= p0_s;
            out_valid_r  <= out_valid_s;
            out_sym_r    <= out_sym_s;
            out_parity_r <= out_parity_s;
            out_last_r   <= out_last_s;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_sym    = out_sym_r;
    assign out_parity = out_parity_r;
    assign out_last   = out_last_r;

endmodule
